multicycle_ctr: RTL and testbench

Multi-cycle main controller for the MIPS-subset datapath: a Moore/Mealy FSM that sequences one shared ALU, one shared instruction/data memory port and the register file across FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK cycles. It replaces the single-cycle opcode decoder when the datapath is rebuilt around a single memory and an instruction register (IR). It also supervises a ready-based memory handshake and traps on illegal opcodes or memory timeouts.

---
 rtl/multicycle_ctr.sv | 252 +++++++++++++++++++++++++
 tb/tb_multicycle_ctr.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctr.sv
// multicycle_ctr: main controller for the multi-cycle MIPS-subset datapath.
// Sequences the shared ALU, the single instruction/data memory port and the
// register file through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK. The memory
// uses a ready handshake; illegal opcodes and memory stalls longer than
// WAIT_MAX cycles halt the controller in a sticky TRAP state.
//
// Optional feature: define MULTICYCLE_CTR_ADDI_EN to add the addi path
// (states ADDI_EX = 12, ADDI_WB = 13). Without it opcode 001000 traps as
// an illegal instruction.
module multicycle_ctr #(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opCode,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       memToReg,
    output logic       regDst,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic [1:0] pcSource,
    output logic       trap,
    output logic [1:0] trapCause,
    output logic [3:0] stateOut
);

    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_TRAP      = 4'd11
`ifdef MULTICYCLE_CTR_ADDI_EN
        ,
        S_ADDI_EX   = 4'd12,
        S_ADDI_WB   = 4'd13
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_CTR_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Stall limit as a 4-bit value matching the wait counter width
    localparam logic [3:0] WAIT_LIM = 4'(WAIT_MAX);

    state_t     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic [1:0] trap_cause_q, trap_cause_d;

    logic       mem_wait_state;
    logic       mem_timeout;

    // States that issue a memory request and therefore may stall on memReady
    always_comb begin
        mem_wait_state = (state_q == S_FETCH) ||
                         (state_q == S_MEM_READ) ||
                         (state_q == S_MEM_WRITE);
        mem_timeout    = mem_wait_state && !memReady && (wait_cnt_q == WAIT_LIM);
    end

    // State, stall counter and trap cause registers; reset aborts any instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_RESET;
            wait_cnt_q   <= 4'd0;
            trap_cause_q <= CAUSE_NONE;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    // Next-state, stall counting and trap cause capture
    always_comb begin
        state_d      = state_q;
        trap_cause_d = trap_cause_q;
        wait_cnt_d   = wait_cnt_q;

        case (state_q)
            S_RESET: state_d = S_FETCH;

            S_FETCH: begin
                if (memReady) state_d = S_DECODE;
            end

            S_DECODE: begin
                case (opCode)
                    OP_RTYPE:      state_d = S_EXECUTE;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
`ifdef MULTICYCLE_CTR_ADDI_EN
                    OP_ADDI:       state_d = S_ADDI_EX;
`endif
                    default: begin
                        state_d      = S_TRAP;
                        trap_cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end

            // The IR still holds the opcode, so it picks the access direction
            S_MEM_ADDR:  state_d = (opCode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;

            S_MEM_READ: begin
                if (memReady) state_d = S_MEM_WB;
            end

            S_MEM_WB:    state_d = S_FETCH;

            S_MEM_WRITE: begin
                if (memReady) state_d = S_FETCH;
            end

            S_EXECUTE:   state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;

`ifdef MULTICYCLE_CTR_ADDI_EN
            S_ADDI_EX:   state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
`endif

            // Absorbing: only the asynchronous reset leaves TRAP
            S_TRAP:      state_d = S_TRAP;

            // Unused encodings restart cleanly from RESET
            default:     state_d = S_RESET;
        endcase

        // A completed access wins over the limit, so timeout needs memReady low
        if (mem_timeout) begin
            state_d      = S_TRAP;
            trap_cause_d = CAUSE_TIMEOUT;
        end

        if (state_d != state_q) begin
            wait_cnt_d = 4'd0;
        end else if (mem_wait_state && !memReady) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    // Control outputs decoded from the state; FETCH PC/IR loads follow memReady
    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memToReg    = 1'b0;
        regDst      = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        aluOp       = 2'b00;
        pcSource    = 2'b00;

        case (state_q)
            S_FETCH: begin
                memRead  = 1'b1;
                aluSrcB  = 2'b01;
                pcWrite  = memReady;
                irWrite  = memReady;
            end
            S_DECODE: begin
                aluSrcB  = 2'b11;
            end
            S_MEM_ADDR: begin
                aluSrcA  = 1'b1;
                aluSrcB  = 2'b10;
            end
            S_MEM_READ: begin
                memRead  = 1'b1;
                iorD     = 1'b1;
            end
            S_MEM_WB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
            end
            S_MEM_WRITE: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
            end
            S_EXECUTE: begin
                aluSrcA  = 1'b1;
                aluOp    = 2'b10;
            end
            S_R_WB: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = 2'b01;
                pcWriteCond = 1'b1;
                pcSource    = 2'b01;
            end
            S_JUMP: begin
                pcWrite  = 1'b1;
                pcSource = 2'b10;
            end
`ifdef MULTICYCLE_CTR_ADDI_EN
            S_ADDI_EX: begin
                aluSrcA  = 1'b1;
                aluSrcB  = 2'b10;
            end
            S_ADDI_WB: begin
                regWrite = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    // Status and debug outputs
    always_comb begin
        trap      = (state_q == S_TRAP);
        trapCause = trap_cause_q;
        stateOut  = state_q;
    end

endmodule

// File: tb/tb_multicycle_ctr.sv
// Directed bench for multicycle_ctr: walks each instruction class, memory
// stalls, the stall limit, illegal opcodes, trap stickiness and reset abort.
module tb_multicycle_ctr;

    logic       clk;
    logic       rst_n;
    logic [5:0] opCode;
    logic       memReady;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic       memToReg, regDst, regWrite, aluSrcA;
    logic [1:0] aluSrcB, aluOp, pcSource;
    logic       trap;
    logic [1:0] trapCause;
    logic [3:0] stateOut;

    int checks = 0;
    int errors = 0;

    multicycle_ctr #(.WAIT_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n), .opCode(opCode), .memReady(memReady),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
        .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
        .memToReg(memToReg), .regDst(regDst), .regWrite(regWrite),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
        .pcSource(pcSource), .trap(trap), .trapCause(trapCause),
        .stateOut(stateOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control vector bit order:
    // pcWrite pcWriteCond iorD memRead memWrite irWrite memToReg regDst
    // regWrite aluSrcA aluSrcB[1:0] aluOp[1:0] pcSource[1:0]
    logic [15:0] ctl;
    assign ctl = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
                  memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource};

    localparam logic [15:0] C_ZERO   = 16'h0000;
    localparam logic [15:0] C_FETCH1 = 16'h9410; // memReady=1
    localparam logic [15:0] C_FETCH0 = 16'h1010; // memReady=0
    localparam logic [15:0] C_DECODE = 16'h0030;
    localparam logic [15:0] C_MADDR  = 16'h0060;
    localparam logic [15:0] C_MREAD  = 16'h3000;
    localparam logic [15:0] C_MWB    = 16'h0280;
    localparam logic [15:0] C_MWRITE = 16'h2800;
    localparam logic [15:0] C_EXEC   = 16'h0048;
    localparam logic [15:0] C_RWB    = 16'h0180;
    localparam logic [15:0] C_BRANCH = 16'h4045;
    localparam logic [15:0] C_JUMP   = 16'h8002;
    localparam logic [15:0] C_ADDIEX = 16'h0060;
    localparam logic [15:0] C_ADDIWB = 16'h0080;

    // {trap, trapCause}
    localparam logic [2:0] T_NONE    = 3'b000;
    localparam logic [2:0] T_ILLEGAL = 3'b101;
    localparam logic [2:0] T_TIMEOUT = 3'b110;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check the current cycle (inputs already applied), then advance one clock
    task automatic cyc(input string tag, input logic [3:0] st, input logic [15:0] c,
                       input logic [2:0] t);
        #1;
        chk({tag, ".state"}, {12'h0, stateOut}, {12'h0, st});
        chk({tag, ".ctl"}, ctl, c);
        chk({tag, ".trap"}, {13'h0, trap, trapCause}, {13'h0, t});
        @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b1;
        opCode   = 6'b000000;
        memReady = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);

        // Reset state, then release: RESET -> FETCH on the next edge
        cyc("rst_hold", 4'd0, C_ZERO, T_NONE);
        rst_n = 1'b1;
        cyc("rst_rel", 4'd0, C_ZERO, T_NONE);

        // R-type with memReady tied high: 1,2,7,8
        opCode = 6'b000000;
        cyc("r.fetch", 4'd1, C_FETCH1, T_NONE);
        cyc("r.decode", 4'd2, C_DECODE, T_NONE);
        cyc("r.exec", 4'd7, C_EXEC, T_NONE);
        cyc("r.wb", 4'd8, C_RWB, T_NONE);

        // lw with three stall cycles in MEM_READ: 8 cycles total
        opCode = 6'b100011;
        cyc("lw.fetch", 4'd1, C_FETCH1, T_NONE);
        cyc("lw.decode", 4'd2, C_DECODE, T_NONE);
        cyc("lw.addr", 4'd3, C_MADDR, T_NONE);
        memReady = 1'b0;
        cyc("lw.rd0", 4'd4, C_MREAD, T_NONE);
        cyc("lw.rd1", 4'd4, C_MREAD, T_NONE);
        cyc("lw.rd2", 4'd4, C_MREAD, T_NONE);
        memReady = 1'b1;
        cyc("lw.rd3", 4'd4, C_MREAD, T_NONE);
        cyc("lw.wb", 4'd5, C_MWB, T_NONE);

        // sw
        opCode = 6'b101011;
        cyc("sw.fetch", 4'd1, C_FETCH1, T_NONE);
        cyc("sw.decode", 4'd2, C_DECODE, T_NONE);
        cyc("sw.addr", 4'd3, C_MADDR, T_NONE);
        cyc("sw.write", 4'd6, C_MWRITE, T_NONE);

        // beq
        opCode = 6'b000100;
        cyc("beq.fetch", 4'd1, C_FETCH1, T_NONE);
        cyc("beq.decode", 4'd2, C_DECODE, T_NONE);
        cyc("beq.branch", 4'd9, C_BRANCH, T_NONE);

        // j
        opCode = 6'b000010;
        cyc("j.fetch", 4'd1, C_FETCH1, T_NONE);
        cyc("j.decode", 4'd2, C_DECODE, T_NONE);
        cyc("j.jump", 4'd10, C_JUMP, T_NONE);

        // FETCH stall: memReady arrives on the limit cycle (16th) -> no trap
        opCode   = 6'b000000;
        memReady = 1'b0;
        for (int i = 0; i < 15; i++) cyc("lim.fetch", 4'd1, C_FETCH0, T_NONE);
        memReady = 1'b1;
        cyc("lim.fetch_last", 4'd1, C_FETCH1, T_NONE);
        cyc("lim.decode", 4'd2, C_DECODE, T_NONE);
        cyc("lim.exec", 4'd7, C_EXEC, T_NONE);
        cyc("lim.wb", 4'd8, C_RWB, T_NONE);

        // Illegal opcode -> sticky TRAP with cause 01
        opCode = 6'b111111;
        cyc("ill.fetch", 4'd1, C_FETCH1, T_NONE);
        cyc("ill.decode", 4'd2, C_DECODE, T_NONE);
        cyc("ill.trap0", 4'd11, C_ZERO, T_ILLEGAL);
        opCode   = 6'b000000;
        memReady = 1'b0;
        cyc("ill.trap1", 4'd11, C_ZERO, T_ILLEGAL);
        memReady = 1'b1;
        cyc("ill.trap2", 4'd11, C_ZERO, T_ILLEGAL);

        // Asynchronous reset leaves TRAP and clears the cause
        rst_n = 1'b0;
        cyc("ill.rst", 4'd0, C_ZERO, T_NONE);
        rst_n = 1'b1;
        cyc("ill.rel", 4'd0, C_ZERO, T_NONE);

        // FETCH stall with memReady held low: 16 FETCH cycles then TRAP cause 10
        memReady = 1'b0;
        for (int i = 0; i < 16; i++) cyc("to.fetch", 4'd1, C_FETCH0, T_NONE);
        cyc("to.trap0", 4'd11, C_ZERO, T_TIMEOUT);
        memReady = 1'b1;
        cyc("to.trap1", 4'd11, C_ZERO, T_TIMEOUT);
        rst_n = 1'b0;
        cyc("to.rst", 4'd0, C_ZERO, T_NONE);
        rst_n = 1'b1;
        cyc("to.rel", 4'd0, C_ZERO, T_NONE);

        // Reset in EXECUTE aborts the R-type: no writeback follows
        opCode = 6'b000000;
        cyc("ab.fetch", 4'd1, C_FETCH1, T_NONE);
        cyc("ab.decode", 4'd2, C_DECODE, T_NONE);
        #1;
        chk("ab.exec_state", {12'h0, stateOut}, 16'h0007);
        rst_n = 1'b0;
        cyc("ab.rst", 4'd0, C_ZERO, T_NONE);
        cyc("ab.rst_hold", 4'd0, C_ZERO, T_NONE);
        rst_n = 1'b1;
        cyc("ab.rel", 4'd0, C_ZERO, T_NONE);

        // addi: extra path only with the feature enabled
        opCode = 6'b001000;
        cyc("addi.fetch", 4'd1, C_FETCH1, T_NONE);
        cyc("addi.decode", 4'd2, C_DECODE, T_NONE);
`ifdef MULTICYCLE_CTR_ADDI_EN
        cyc("addi.ex", 4'd12, C_ADDIEX, T_NONE);
        cyc("addi.wb", 4'd13, C_ADDIWB, T_NONE);
        opCode = 6'b000000;
        cyc("addi.next", 4'd1, C_FETCH1, T_NONE);
`else
        cyc("addi.trap", 4'd11, C_ZERO, T_ILLEGAL);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
